// File: rtl/tron_pkg.sv
// Shared definitions for the Tron round sequencer: direction codes, colours,
// winner codes, FSM states and small steering helpers.
package tron_pkg;

  localparam int ADDR_W = 15;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BORDER = 3'b111;
  localparam logic [2:0] COL_P1     = 3'b101;
  localparam logic [2:0] COL_P2     = 3'b011;

  localparam logic [1:0] WIN_NONE = 2'b00;

  // HEAD1/HEAD2 are the two head-drawing cycles that finish the clear sweep.
  typedef enum logic [3:0] {
    ST_IDLE, ST_CLEAR, ST_HEAD1, ST_HEAD2, ST_WAIT,
    ST_RD1, ST_RD2, ST_CHK, ST_WR1, ST_WR2, ST_OVER
  } state_e;

  // Opposite direction: up<->down, left<->right.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // A requested direction that would U-turn into the own trail is dropped.
  function automatic logic [1:0] steer(input logic [1:0] cur, input logic [1:0] req);
    return (req == reverse_dir(cur)) ? cur : req;
  endfunction

  function automatic logic [7:0] step_x(input logic [7:0] x, input logic [1:0] d);
    logic [7:0] r;
    case (d)
      DIR_LEFT:  r = x - 8'd1;
      DIR_RIGHT: r = x + 8'd1;
      default:   r = x;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] step_y(input logic [6:0] y, input logic [1:0] d);
    logic [6:0] r;
    case (d)
      DIR_UP:   r = y - 7'd1;
      DIR_DOWN: r = y + 7'd1;
      default:  r = y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tron_tick_divider.sv
// Game-tick divider: counts 0..TICK_DIV-1 while enabled and pulses tick for
// one cycle on the terminal count. Disabling clears the count so every WAIT
// period is a full TICK_DIV cycles long.
module tron_tick_divider #(
  parameter int TICK_DIV = 2000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TERM    = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and terminal-count pulse.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == TERM) begin
      cnt_d = {CW{1'b0}};
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= {CW{1'b0}};
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tron_round_sequencer.sv
// Tron round sequencer: clears the screen, draws border and heads, then moves
// both light-cycles once per tick, checking the occupancy RAM for collisions.
// All VGA and occupancy outputs are registered; values computed in a state
// are presented during the following state.
module tron_round_sequencer
  import tron_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int TICK_DIV = 2000000,
  parameter int P1_X0    = 5,
  parameter int P1_Y0    = 5,
  parameter int P2_X0    = 154,
  parameter int P2_Y0    = 114
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        p1_dir,
  input  logic [1:0]        p2_dir,
  output logic [ADDR_W-1:0] occ_addr,
  output logic              occ_we,
  output logic              occ_wdata,
  input  logic              occ_rdata,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic              round_over,
  output logic [1:0]        winner
);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0] P1X = 8'(P1_X0);
  localparam logic [6:0] P1Y = 7'(P1_Y0);
  localparam logic [7:0] P2X = 8'(P2_X0);
  localparam logic [6:0] P2Y = 7'(P2_Y0);

  state_e      state_q, state_d;
  logic [7:0]  cx_q, cx_d, h1x_q, h1x_d, h2x_q, h2x_d, n1x_q, n1x_d, n2x_q, n2x_d;
  logic [6:0]  cy_q, cy_d, h1y_q, h1y_d, h2y_q, h2y_d, n1y_q, n1y_d, n2y_q, n2y_d;
  logic [1:0]  d1_q, d1_d, d2_q, d2_d, winner_q, winner_d;
  logic        occ1_q, occ1_d, busy_q, busy_d, over_q, over_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d, occ_we_q, occ_we_d, occ_wdata_q, occ_wdata_d;
  logic [ADDR_W-1:0] occ_addr_q, occ_addr_d;

  logic        tick_s, same_s, lose1_s, lose2_s, plot_s, clr_pix_s, border_s;
  logic [7:0]  px_s;
  logic [6:0]  py_s;
  logic [2:0]  pcol_s;

  tron_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_q == ST_WAIT),
    .tick   (tick_s)
  );

  assign same_s = (n1x_q == n2x_q) && (n1y_q == n2y_q);

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d = state_q;  cx_d = cx_q;  cy_d = cy_q;
    h1x_d = h1x_q;  h1y_d = h1y_q;  h2x_d = h2x_q;  h2y_d = h2y_q;
    n1x_d = n1x_q;  n1y_d = n1y_q;  n2x_d = n2x_q;  n2y_d = n2y_q;
    d1_d = d1_q;  d2_d = d2_q;  occ1_d = occ1_q;  winner_d = winner_q;
    occ_addr_d = occ_addr_q;
    lose1_s = 1'b0;  lose2_s = 1'b0;  border_s = 1'b0;
    plot_s = 1'b0;  clr_pix_s = 1'b0;
    px_s = 8'd0;  py_s = 7'd0;  pcol_s = COL_BLACK;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_CLEAR;  cx_d = 8'd0;  cy_d = 7'd0;  clr_pix_s = 1'b1;
          h1x_d = P1X;  h1y_d = P1Y;  h2x_d = P2X;  h2y_d = P2Y;
          d1_d = DIR_RIGHT;  d2_d = DIR_LEFT;  winner_d = WIN_NONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_CLEAR: begin
        if (cx_q == X_LAST && cy_q == Y_LAST) begin
          state_d = ST_HEAD1;
          plot_s = 1'b1;  px_s = h1x_q;  py_s = h1y_q;  pcol_s = COL_P1;
        end else if (cx_q == X_LAST) begin
          cx_d = 8'd0;  cy_d = cy_q + 7'd1;  clr_pix_s = 1'b1;
        end else begin
          cx_d = cx_q + 8'd1;  clr_pix_s = 1'b1;
        end
      end
      ST_HEAD1: begin
        state_d = ST_HEAD2;
        plot_s = 1'b1;  px_s = h2x_q;  py_s = h2y_q;  pcol_s = COL_P2;
      end
      ST_HEAD2: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tick_s) begin
          d1_d = steer(d1_q, p1_dir);
          d2_d = steer(d2_q, p2_dir);
          n1x_d = step_x(h1x_q, d1_d);  n1y_d = step_y(h1y_q, d1_d);
          n2x_d = step_x(h2x_q, d2_d);  n2y_d = step_y(h2y_q, d2_d);
          occ_addr_d = {n1y_d, n1x_d};
          state_d = ST_RD1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RD1: begin
        occ_addr_d = {n2y_q, n2x_q};
        state_d = ST_RD2;
      end
      ST_RD2: begin
        occ1_d = occ_rdata;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        lose1_s = occ1_q | same_s;
        lose2_s = occ_rdata | same_s;
        if (lose1_s || lose2_s) begin
          winner_d = {lose1_s, lose2_s};
          state_d = ST_OVER;
        end else begin
          state_d = ST_WR1;
          plot_s = 1'b1;  px_s = n1x_q;  py_s = n1y_q;  pcol_s = COL_P1;
        end
      end
      ST_WR1: begin
        h1x_d = n1x_q;  h1y_d = n1y_q;  state_d = ST_WR2;
        plot_s = 1'b1;  px_s = n2x_q;  py_s = n2y_q;  pcol_s = COL_P2;
      end
      ST_WR2: begin
        h2x_d = n2x_q;  h2y_d = n2y_q;  state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Raster pixel of the clear sweep: border cells white and occupied.
    if (clr_pix_s) begin
      border_s = (cx_d == 8'd0) || (cx_d == X_LAST) || (cy_d == 7'd0) || (cy_d == Y_LAST);
      plot_s = 1'b1;  px_s = cx_d;  py_s = cy_d;
      pcol_s = border_s ? COL_BORDER : COL_BLACK;
    end else begin
      border_s = 1'b0;
    end

    vga_x_d = vga_x_q;  vga_y_d = vga_y_q;  vga_colour_d = vga_colour_q;
    occ_wdata_d = occ_wdata_q;
    vga_plot_d = plot_s;  occ_we_d = plot_s;
    if (plot_s) begin
      vga_x_d = px_s;  vga_y_d = py_s;  vga_colour_d = pcol_s;
      occ_addr_d = {py_s, px_s};
      occ_wdata_d = (pcol_s != COL_BLACK);
    end else begin
      vga_plot_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_OVER);
    over_d = (state_d == ST_OVER);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;  cx_q <= 8'd0;  cy_q <= 7'd0;
      h1x_q <= P1X;  h1y_q <= P1Y;  h2x_q <= P2X;  h2y_q <= P2Y;
      n1x_q <= 8'd0;  n1y_q <= 7'd0;  n2x_q <= 8'd0;  n2y_q <= 7'd0;
      d1_q <= DIR_RIGHT;  d2_q <= DIR_LEFT;  occ1_q <= 1'b0;  winner_q <= WIN_NONE;
      busy_q <= 1'b0;  over_q <= 1'b0;
      vga_x_q <= 8'd0;  vga_y_q <= 7'd0;  vga_colour_q <= COL_BLACK;  vga_plot_q <= 1'b0;
      occ_addr_q <= {ADDR_W{1'b0}};  occ_we_q <= 1'b0;  occ_wdata_q <= 1'b0;
    end else begin
      state_q <= state_d;  cx_q <= cx_d;  cy_q <= cy_d;
      h1x_q <= h1x_d;  h1y_q <= h1y_d;  h2x_q <= h2x_d;  h2y_q <= h2y_d;
      n1x_q <= n1x_d;  n1y_q <= n1y_d;  n2x_q <= n2x_d;  n2y_q <= n2y_d;
      d1_q <= d1_d;  d2_q <= d2_d;  occ1_q <= occ1_d;  winner_q <= winner_d;
      busy_q <= busy_d;  over_q <= over_d;
      vga_x_q <= vga_x_d;  vga_y_q <= vga_y_d;  vga_colour_q <= vga_colour_d;
      vga_plot_q <= vga_plot_d;
      occ_addr_q <= occ_addr_d;  occ_we_q <= occ_we_d;  occ_wdata_q <= occ_wdata_d;
    end
  end

  assign occ_addr   = occ_addr_q;
  assign occ_we     = occ_we_q;
  assign occ_wdata  = occ_wdata_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign round_over = over_q;
  assign winner     = winner_q;
endmodule

// File: tb/tb_tron_round_sequencer.sv
// Directed bench for tron_round_sequencer on a 16x12 screen with TICK_DIV=8.
module tb_tron_round_sequencer;
  localparam int W = 16;
  localparam int H = 12;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  p1_dir = 2'b11;
  logic [1:0]  p2_dir = 2'b10;
  logic [14:0] occ_addr;
  logic        occ_we, occ_wdata;
  logic        occ_rdata = 1'b0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, round_over;
  logic [1:0]  winner;

  int vectors = 0;
  int miscompares = 0;
  logic occ_mem [0:32767];

  tron_round_sequencer #(
    .SCREEN_W(16), .SCREEN_H(12), .TICK_DIV(8),
    .P1_X0(5), .P1_Y0(5), .P2_X0(10), .P2_Y0(10)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .p1_dir(p1_dir), .p2_dir(p2_dir),
    .occ_addr(occ_addr), .occ_we(occ_we), .occ_wdata(occ_wdata), .occ_rdata(occ_rdata),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .round_over(round_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous occupancy RAM.
  always @(posedge clk) begin
    if (occ_we) occ_mem[occ_addr] <= occ_wdata;
    occ_rdata <= occ_mem[occ_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a plot, check every plot/occupancy field, consume it.
  task automatic expect_plot(input string tag, input int max_wait, input logic [7:0] ex,
                             input logic [6:0] ey, input logic [2:0] ec);
    int n;
    logic ow;
    n = 0;
    ow = (ec != 3'b000);
    while (vga_plot !== 1'b1 && n < max_wait) begin
      step();
      n++;
    end
    check($sformatf("%s plot(%0d,%0d)", tag, ex, ey),
          64'({vga_plot, vga_x, vga_y, vga_colour, occ_we, occ_wdata, occ_addr}),
          64'({1'b1, ex, ey, ec, 1'b1, ow, ey, ex}));
    step();
  endtask

  task automatic expect_clear(input string tag);
    logic b;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        b = (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
        expect_plot(tag, 0, x[7:0], y[6:0], b ? 3'b111 : 3'b000);
      end
    end
    expect_plot({tag, " p1head"}, 0, 8'd5, 7'd5, 3'b101);
    expect_plot({tag, " p2head"}, 0, 8'd10, 7'd10, 3'b011);
    check({tag, " wait busy/plot"}, 64'({busy, vga_plot, round_over}), 64'({1'b1, 1'b0, 1'b0}));
  endtask

  task automatic expect_tick(input string tag, input logic [7:0] x1, input logic [6:0] y1,
                             input logic [7:0] x2, input logic [6:0] y2);
    expect_plot({tag, " p1"}, 40, x1, y1, 3'b101);
    expect_plot({tag, " p2"}, 0, x2, y2, 3'b011);
    check({tag, " two plots only"}, 64'(vga_plot), 64'(0));
  endtask

  task automatic expect_over(input string tag, input logic [1:0] win);
    int n;
    int plots;
    n = 0;
    plots = 0;
    while (round_over !== 1'b1 && n < 40) begin
      if (vga_plot === 1'b1) plots++;
      step();
      n++;
    end
    check({tag, " round_over"}, 64'(round_over), 64'(1));
    check({tag, " no pixel"}, 64'(plots), 64'(0));
    check({tag, " winner"}, 64'(winner), 64'(win));
    check({tag, " busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    // Reset state.
    #12;
    check("reset outputs",
          64'({vga_x, vga_y, vga_colour, vga_plot, occ_addr, occ_we, occ_wdata, busy, round_over, winner}),
          64'd0);
    resetn = 1'b1;
    step();

    // Start a clear and abort it with reset at pixel 50.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      expect_plot("partial", 0, 8'(i % W), 7'(i / W),
                  ((i % W == 0) || (i % W == W - 1) || (i / W == 0)) ? 3'b111 : 3'b000);
    end
    resetn = 1'b0;
    #1;
    check("async reset outputs",
          64'({vga_x, vga_y, vga_colour, vga_plot, occ_addr, occ_we, occ_wdata, busy, round_over, winner}),
          64'd0);
    #1;
    resetn = 1'b1;
    step();

    // Full clear plus heads.
    start = 1'b1;
    step();
    start = 1'b0;
    expect_clear("clear1");

    // start during WAIT is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start in wait ignored", 64'({busy, round_over, vga_plot}), 64'({1'b1, 1'b0, 1'b0}));

    // Three ticks with unchanged directions.
    expect_tick("t1", 8'd6, 7'd5, 8'd9, 7'd10);
    expect_tick("t2", 8'd7, 7'd5, 8'd8, 7'd10);
    expect_tick("t3", 8'd8, 7'd5, 8'd7, 7'd10);

    // P1 requests a reversal (ignored); P2 turns up, then right.
    p1_dir = 2'b10;
    p2_dir = 2'b00;
    expect_tick("t4", 8'd9, 7'd5, 8'd7, 7'd9);
    p2_dir = 2'b11;
    expect_tick("t5", 8'd10, 7'd5, 8'd8, 7'd9);
    expect_tick("t6", 8'd11, 7'd5, 8'd9, 7'd9);
    expect_tick("t7", 8'd12, 7'd5, 8'd10, 7'd9);
    expect_tick("t8", 8'd13, 7'd5, 8'd11, 7'd9);
    expect_tick("t9", 8'd14, 7'd5, 8'd12, 7'd9);
    expect_over("border hit", 2'b10);

    // OVER holds without start.
    for (int i = 0; i < 5; i++) step();
    check("over holds", 64'({round_over, busy, winner}), 64'({1'b1, 1'b0, 2'b10}));

    // Second round: start in OVER re-enters CLEAR.
    p1_dir = 2'b11;
    p2_dir = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    check("over->clear", 64'({round_over, busy}), 64'({1'b0, 1'b1}));
    expect_clear("clear2");

    // P2 climbs column 10 while P1 runs along row 5: both aim at (10,5).
    expect_tick("r2t1", 8'd6, 7'd5, 8'd10, 7'd9);
    expect_tick("r2t2", 8'd7, 7'd5, 8'd10, 7'd8);
    expect_tick("r2t3", 8'd8, 7'd5, 8'd10, 7'd7);
    expect_tick("r2t4", 8'd9, 7'd5, 8'd10, 7'd6);
    expect_over("head-on", 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
